// File: rtl/core_pkg.sv
// Shared types and constants for the core's memory-side blocks.
// Adds the data RAM request/response shapes, FSM states and strobe legality rule.
package core;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strb_t;

  localparam word_t       DATA_BASE = 32'h0000_0000;
  localparam int unsigned DATA_SIZE = 512;

  typedef struct packed {
    word_t addr;
    logic  write;
    strb_t strb;
    word_t wdata;
  } mem_req_t;

  typedef struct packed {
    word_t rdata;
    logic  err;
  } mem_rsp_t;

  typedef enum logic [1:0] {IDLE, WAIT_ST, RESP} ram_state_t;

  // Naturally aligned word, halfword and byte accesses only.
  function automatic logic strb_legal(input logic [1:0] addr_lo, input strb_t strb);
    logic ok;
    ok = 1'b0;
    case (strb)
      4'b1111, 4'b0011, 4'b0001: ok = (addr_lo == 2'd0);
      4'b0010:                   ok = (addr_lo == 2'd1);
      4'b1100, 4'b0100:          ok = (addr_lo == 2'd2);
      4'b1000:                   ok = (addr_lo == 2'd3);
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/byte_ram.sv
// DEPTH x 32-bit storage with per-byte write enables and registered read.
// Contents are never reset.
module byte_ram #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][b] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_ram.sv
// Data-side RAM with a valid/ready request channel, optional fixed wait states
// and a held response; faults on out-of-range addresses and misaligned strobes.
module data_ram
  import core::*;
#(
  parameter word_t       BASE  = DATA_BASE,
  parameter int unsigned DEPTH = DATA_SIZE / 4,
  parameter int unsigned WAIT  = 0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  req_valid,
  output logic  req_ready,
  input  word_t req_addr,
  input  logic  req_write,
  input  strb_t req_strb,
  input  word_t req_wdata,
  output logic  rsp_valid,
  input  logic  rsp_ready,
  output word_t rsp_rdata,
  output logic  rsp_err
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  CNT_INIT = (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);
  localparam logic [32:0] SPAN     = 33'(4 * DEPTH);

  ram_state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  mem_req_t   req;
  mem_rsp_t   rsp;
  word_t      offset;
  logic       in_range, legal, accept, rd_ok, err_q;
  logic [3:0] we;
  logic       re;
  word_t      ram_rdata;

  assign req = '{addr: req_addr, write: req_write, strb: req_strb, wdata: req_wdata};

  // Subtract first, then bound the offset: avoids wrap when BASE+4*DEPTH overflows.
  assign offset   = req.addr - BASE;
  assign in_range = (req.addr >= BASE) && ({1'b0, offset} < SPAN);
  assign legal    = in_range && strb_legal(req.addr[1:0], req.strb);

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign we        = (accept && req.write && legal) ? req.strb : '0;
  assign re        = accept && !req.write && legal;

  byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_byte_ram (
    .clk   (clk),
    .addr  (offset[AW+1:2]),
    .we    (we),
    .re    (re),
    .wdata (req.wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rd_ok <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        rd_ok <= re;
        err_q <= !legal;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT_ST;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT_ST: begin
        if (cnt == 3'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 3'd1;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM output only moves on a load accept, so gating it holds data stable in RESP.
  assign rsp = '{rdata: rd_ok ? ram_rdata : '0, err: err_q};

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp.rdata;
  assign rsp_err   = rsp.err;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: a WAIT=0 and a WAIT=3 instance against a byte-array model.
module tb_data_ram;

  localparam int unsigned RAM_BYTES = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        req_write [2];
  logic [3:0]  req_strb  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [2][RAM_BYTES];
  int         exp_lat [2];

  always #5 clk = ~clk;

  data_ram #(.WAIT(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_write(req_write[0]), .req_strb(req_strb[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  data_ram #(.WAIT(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_write(req_write[1]), .req_strb(req_strb[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  // Reference: aligned word/half/byte accesses inside the first 512 bytes are legal.
  function automatic bit ref_legal(input logic [31:0] addr, input logic [3:0] strb);
    bit ok_strb;
    ok_strb = (strb == 4'b1111 && addr[1:0] == 2'd0) ||
              (strb == 4'b0011 && addr[1:0] == 2'd0) ||
              (strb == 4'b1100 && addr[1:0] == 2'd2) ||
              (strb == (4'b0001 << addr[1:0]));
    return (addr < RAM_BYTES) && ok_strb;
  endfunction

  function automatic void ref_access(input int sel, input logic [31:0] addr, input logic wr,
                                     input logic [3:0] strb, input logic [31:0] wdata,
                                     output logic [31:0] rdata, output logic err);
    int unsigned base;
    rdata = '0;
    err   = 1'b0;
    if (!ref_legal(addr, strb)) begin
      err = 1'b1;
      return;
    end
    base = addr & 32'hFFFF_FFFC;
    for (int b = 0; b < 4; b++) begin
      if (wr) begin
        if (strb[b]) ref_mem[sel][base + b] = wdata[8*b +: 8];
      end else begin
        rdata[8*b +: 8] = ref_mem[sel][base + b];
      end
    end
  endfunction

  // Drives one transaction; reports response, latency from accept edge, hold stability.
  task automatic access(input int sel, input logic [31:0] addr, input logic wr,
                        input logic [3:0] strb, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output bit stable, output bit idle_after, output bit timeout);
    int guard;
    timeout = 0; stable = 1; idle_after = 0; lat = 0; rdata = '0; err = 1'b0;
    @(negedge clk);
    req_valid[sel] = 1'b1;
    req_addr[sel]  = addr;
    req_write[sel] = wr;
    req_strb[sel]  = strb;
    req_wdata[sel] = wdata;
    rsp_ready[sel] = 1'b0;
    guard = 0;
    while (!req_ready[sel] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[sel]) begin
      timeout = 1;
      req_valid[sel] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[sel] = 1'b0;
    req_addr[sel]  = $urandom;
    req_write[sel] = 1'($urandom);
    req_strb[sel]  = 4'($urandom);
    req_wdata[sel] = $urandom;
    lat = 1;
    if (req_ready[sel]) stable = 0;
    while (!rsp_valid[sel] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (req_ready[sel]) stable = 0;
    end
    if (!rsp_valid[sel]) begin
      timeout = 1;
      return;
    end
    rdata = rsp_rdata[sel];
    err   = rsp_err[sel];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (!rsp_valid[sel] || rsp_rdata[sel] !== rdata || rsp_err[sel] !== err || req_ready[sel])
        stable = 0;
    end
    rsp_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[sel] = 1'b0;
    idle_after = req_ready[sel] && !rsp_valid[sel];
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_addr[s] = '0; req_write[s] = 1'b0;
      req_strb[s] = '0; req_wdata[s] = '0; rsp_ready[s] = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (rsp_valid[s] !== 1'b0 || rsp_err[s] !== 1'b0 || rsp_rdata[s] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got valid=%b err=%b rdata=%h expected 0/0/00000000",
                 s, rsp_valid[s], rsp_err[s], rsp_rdata[s]);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (req_ready[s] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready[%0d]: got %b expected 1", s, req_ready[s]);
      end
    end
  endtask

  task automatic test_init();
    logic [31:0] rd; logic er, eer; logic [31:0] erd; int lat; bit st, idl, to;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 128; w++) begin
        ref_access(s, 32'(w * 4), 1'b1, 4'hF, 32'h0, erd, eer);
        access(s, 32'(w * 4), 1'b1, 4'hF, 32'h0, 0, rd, er, lat, st, idl, to);
        checks++;
        if (to || er !== eer) begin
          errors++;
          $display("FAIL init_store[%0d] w=%0d: got err=%b timeout=%0d expected err=0", s, w, er, to);
        end
      end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic test_directed();
    vec_t v [10];
    logic [31:0] rd, mrd; logic er, mer; int lat; bit st, idl, to;
    v[0] = '{32'h10,       1'b1, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
    v[1] = '{32'h10,       1'b0, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
    v[2] = '{32'h12,       1'b1, 4'b1100, 32'h12340000, 32'h0,        1'b0};
    v[3] = '{32'h10,       1'b0, 4'b1111, 32'h0,        32'h1234BEEF, 1'b0};
    v[4] = '{32'h200,      1'b0, 4'b1111, 32'h0,        32'h0,        1'b1};
    v[5] = '{32'h11,       1'b1, 4'b0011, 32'hFFFFFFFF, 32'h0,        1'b1};
    v[6] = '{32'h10,       1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
    v[7] = '{32'h10,       1'b0, 4'b0001, 32'h0,        32'h1234BEEF, 1'b0};
    v[8] = '{32'h1FC,      1'b0, 4'b1111, 32'h0,        32'h0,        1'b0};
    v[9] = '{32'hFFFFFFFC, 1'b0, 4'b1111, 32'h0,        32'h0,        1'b1};
    foreach (v[i]) begin
      ref_access(0, v[i].addr, v[i].wr, v[i].strb, v[i].wdata, mrd, mer);
      access(0, v[i].addr, v[i].wr, v[i].strb, v[i].wdata, 0, rd, er, lat, st, idl, to);
      checks++;
      if (to || rd !== v[i].exp_rdata || er !== v[i].exp_err) begin
        errors++;
        $display("FAIL directed[%0d]: got rdata=%h err=%b timeout=%0d expected rdata=%h err=%b",
                 i, rd, er, to, v[i].exp_rdata, v[i].exp_err);
      end
      checks++;
      if (lat != 1 || !idl) begin
        errors++;
        $display("FAIL directed_timing[%0d]: got latency=%0d idle_after=%0d expected latency=1 idle_after=1",
                 i, lat, idl);
      end
    end
  endtask

  task automatic test_wait_hold();
    logic [31:0] rd, mrd, d; logic er, mer; int lat; bit st, idl, to;
    d = $urandom;
    ref_access(1, 32'h40, 1'b1, 4'hF, d, mrd, mer);
    access(1, 32'h40, 1'b1, 4'hF, d, 0, rd, er, lat, st, idl, to);
    checks++;
    if (to || lat != 4 || er !== 1'b0) begin
      errors++;
      $display("FAIL wait_store: got latency=%0d err=%b timeout=%0d expected latency=4 err=0", lat, er, to);
    end
    access(1, 32'h40, 1'b0, 4'hF, 32'h0, 5, rd, er, lat, st, idl, to);
    checks++;
    if (to || rd !== d || er !== 1'b0) begin
      errors++;
      $display("FAIL wait_load_data: got rdata=%h err=%b expected rdata=%h err=0", rd, er, d);
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL wait_latency: got %0d expected 4", lat);
    end
    checks++;
    if (!st || !idl) begin
      errors++;
      $display("FAIL wait_hold_stable: got stable=%0d idle_after=%0d expected 1/1", st, idl);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, mrd, d; logic er, mer; int lat; bit st, idl, to, seen;
    d = $urandom;
    ref_access(1, 32'h20, 1'b1, 4'hF, d, mrd, mer);
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = 32'h20; req_write[1] = 1'b1;
    req_strb[1] = 4'hF; req_wdata[1] = d; rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    seen = rsp_valid[1];
    repeat (6) begin
      @(posedge clk);
      #1;
      if (rsp_valid[1] || rsp_valid[0]) seen = 1;
    end
    @(negedge clk);
    reset = 1'b0;
    rsp_ready[1] = 1'b0;
    #1;
    if (rsp_valid[1]) seen = 1;
    checks++;
    if (seen || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_discard: got rsp_valid_seen=%0d req_ready=%b expected 0/1", seen, req_ready[1]);
    end
    access(1, 32'h20, 1'b0, 4'hF, 32'h0, 0, rd, er, lat, st, idl, to);
    checks++;
    if (to || rd !== d || er !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL reset_mid_store_kept: got rdata=%h err=%b latency=%0d expected rdata=%h err=0 latency=4",
               rd, er, lat, d);
    end
  endtask

  task automatic test_random(input int sel, input int n);
    logic [31:0] addr, wdata, rd, mrd; logic [3:0] strb; logic wr, er, mer;
    int lat, hold, k; bit st, idl, to;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = 32'($urandom_range(0, 32'h21F));
      if ($urandom_range(0, 3) == 0) begin
        strb = 4'($urandom);
      end else begin
        k = $urandom_range(0, 3);
        case (k)
          0:       begin strb = 4'b1111; addr[1:0] = 2'd0; end
          1:       begin strb = 4'b0011; addr[1:0] = 2'd0; end
          2:       begin strb = 4'b1100; addr[1:0] = 2'd2; end
          default: begin strb = 4'b0001 << addr[1:0]; end
        endcase
      end
      wr    = 1'($urandom);
      wdata = $urandom;
      hold  = $urandom_range(0, 2);
      ref_access(sel, addr, wr, strb, wdata, mrd, mer);
      access(sel, addr, wr, strb, wdata, hold, rd, er, lat, st, idl, to);
      checks++;
      if (to || rd !== mrd || er !== mer || lat != exp_lat[sel] || !st || !idl) begin
        errors++;
        $display("FAIL random[%0d:%0d] addr=%h wr=%b strb=%b: got rdata=%h err=%b lat=%0d stable=%0d idle=%0d to=%0d expected rdata=%h err=%b lat=%0d",
                 sel, i, addr, wr, strb, rd, er, lat, st, idl, to, mrd, mer, exp_lat[sel]);
      end
    end
  endtask

  initial begin
    exp_lat[0] = 1;
    exp_lat[1] = 4;
    test_reset();
    test_init();
    test_directed();
    test_wait_hold();
    test_reset_mid();
    test_random(0, 10000);
    test_random(1, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 The block SHALL have parameter BASE, default DATA_BASE (32'h00000000), which is the byte address of word 0.
REQ-002 The block SHALL have parameter DEPTH, default DATA_SIZE/4 (128), which is the number of 32-bit words.
REQ-003 The block SHALL have parameter WAIT, default 0, range 0..7, which sets the extra cycles inserted before each response.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, 1 bit: the request is valid.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block accepts the request.
REQ-008 The block SHALL have port req_addr, input, 32 bits (word_t): the byte address.
REQ-009 The block SHALL have port req_write, input, 1 bit: 1 for store, 0 for load.
REQ-010 The block SHALL have port req_strb, input, 4 bits (strb_t): the byte lanes to access.
REQ-011 The block SHALL have port req_wdata, input, 32 bits: the store data, already lane-aligned.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: the response is valid.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the requester takes the response.
REQ-014 The block SHALL have port rsp_rdata, output, 32 bits: the full word read, unshifted.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: access fault.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT_ST and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; it is a combinational function of state.
REQ-018 A request SHALL be accepted on a clk edge where req_valid and req_ready are both 1.
- With WAIT=0, the FSM goes IDLE->RESP.
- Otherwise it goes IDLE->WAIT_ST, loading a counter with WAIT-1.
REQ-019 WAIT_ST SHALL decrement the counter each cycle and go to RESP after the cycle in which the counter is 0; rsp_valid therefore rises exactly 1+WAIT cycles after acceptance.
REQ-020 RESP SHALL hold rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE on that edge.
REQ-021 Throughput SHALL be one access per 2+WAIT cycles minimum.
REQ-022 The range check SHALL be BASE <= req_addr < BASE+4*DEPTH, using unsigned 32-bit arithmetic with no wrap; the word index is (req_addr-BASE)>>2.
REQ-023 Legal strobes SHALL be:
- 4'b1111 with addr[1:0]=00;
- 4'b0011 with addr[1:0]=00;
- 4'b1100 with addr[1:0]=10;
- a single bit i with addr[1:0]=i.
All other combinations, including 4'b0000, are illegal.
REQ-024 An access that is out of range or uses an illegal strobe SHALL respond with rsp_err=1 and rsp_rdata=0, and memory SHALL be unchanged.
REQ-025 A legal store SHALL update only the strobed bytes on the accept edge, and respond with rsp_err=0 and rsp_rdata=0.
REQ-026 A legal load SHALL capture the whole word on the accept edge, ignoring strobes for data, and respond with rsp_err=0; sign extension and lane selection belong to the core.
REQ-027 A load accepted after a store to the same word SHALL return the stored bytes merged with the prior unstrobed bytes.
REQ-028 The block SHALL ignore req_* while not in IDLE; a request held with req_valid=1 is accepted on the first IDLE cycle.

Reset
REQ-029 On reset assertion the block SHALL immediately set: state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready=1 after reset deasserts.
REQ-030 Reset asserted mid-access (WAIT_ST or RESP) SHALL discard the pending response; any store already committed on its accept edge remains.
REQ-031 Memory contents SHALL NOT be reset.

Structure
REQ-032 Package core SHALL gain the following, while reusing word_t, strb_t, DATA_BASE and DATA_SIZE:
- mem_req_t (addr, write, strb, wdata);
- mem_rsp_t (rdata, err);
- enum ram_state_t {IDLE, WAIT_ST, RESP};
- function strb_legal(addr[1:0], strb).
REQ-033 Storage SHALL be one sub-module, byte_ram: DEPTH x 4 bytes, with per-byte write enables, synchronous read and write, and no reset.

Verification
REQ-034 With WAIT=0: store addr 0x10, strb 1111, data 0xDEADBEEF, then load 0x10 -> rsp_rdata=0xDEADBEEF, err=0, rsp_valid 1 cycle after each accept.
REQ-035 Store addr 0x12, strb 1100, data 0x12340000 over 0xDEADBEEF, then load 0x10 -> 0x1234BEEF.
REQ-036 Load 0x200 (BASE+4*DEPTH) -> err=1, rdata=0; store 0x11 with strb 0011 -> err=1, and a subsequent load of 0x10 is unchanged.
REQ-037 With WAIT=3 and rsp_ready held low for 5 cycles: rsp_valid rises 4 cycles after accept, data stays stable, req_ready=0 throughout, and IDLE is resumed the cycle after rsp_ready=1.
REQ-038 Assert reset while in WAIT_ST after a store to 0x20 -> rsp_valid stays 0 and a later load of 0x20 returns the stored data.
REQ-039 Random legal/illegal traffic with random rsp_ready against a reference byte-array model -> no mismatch over 10k accesses.
